// File: rtl/decode_queue_stage_pkg.sv
// Shared definitions for the decode queue stage.
// - Exception codes carried with fetched instructions.
// - RS/RT field extraction helpers for MIPS-style instruction words.
// - Packed layout of one queue entry.
package decode_queue_stage_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;

  // One queue entry. Exception entries are marked filled when they are
  // allocated because no memory response will ever arrive for them.
  typedef struct packed {
    logic [31:0] pc;
    logic        exc;
    logic [4:0]  exccode;
    logic [31:0] inst;
    logic        filled;
  } q_entry_t;

  localparam int ENTRY_W = $bits(q_entry_t);

  function automatic logic [4:0] inst_rs(input logic [31:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [31:0] inst);
    return inst[20:16];
  endfunction

endpackage

// File: rtl/decode_queue_stage_inst_queue.sv
// inst_queue: in-order storage for fetched instructions.
// Ports: fetch allocate (req_*), instruction response (inst_*), flush_i,
// pop_i from the issue logic, head entry view (head_*) and occupancy.
// Tracks head/tail pointers, the fill target (oldest entry still waiting
// for a response), count and the number of responses to discard.
module inst_queue
  import decode_queue_stage_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_pc_i,
  input  logic                   req_exc_i,
  input  logic [4:0]             req_exccode_i,
  input  logic                   inst_data_ok_i,
  input  logic [31:0]            inst_rdata_i,
  input  logic                   flush_i,
  input  logic                   pop_i,
  output logic                   head_ready_o,
  output logic [31:0]            head_pc_o,
  output logic [31:0]            head_inst_o,
  output logic                   head_exc_o,
  output logic [4:0]             head_exccode_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 1;

  q_entry_t          mem_q [DEPTH];
  q_entry_t          mem_d [DEPTH];
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d, discard_q, discard_d;
  logic [PW-1:0]     fill_idx_s, scan_idx_s;
  logic              fill_found_s, fill_now_s, alloc_s, drop_s;
  logic [CW-1:0]     unfilled_s;
  q_entry_t          head_ent_s;

  // Fill pointer: first unfilled entry walking from head; exception entries
  // are already filled so they are skipped naturally.
  always_comb begin
    fill_found_s = 1'b0;
    fill_idx_s   = head_q;
    scan_idx_s   = head_q;
    unfilled_s   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx_s = head_q + PW'(k);
      if ((CW'(k) < count_q) && !mem_q[scan_idx_s].filled) begin
        unfilled_s = unfilled_s + CW'(1'b1);
        if (!fill_found_s) begin
          fill_found_s = 1'b1;
          fill_idx_s   = scan_idx_s;
        end else begin
          fill_found_s = 1'b1;
        end
      end else begin
        unfilled_s = unfilled_s;
      end
    end
  end

  assign fill_now_s  = inst_data_ok_i && (discard_q == '0) && fill_found_s;
  // A response consumes either a discard slot or the fill target.
  assign drop_s      = inst_data_ok_i && ((discard_q != '0) || fill_found_s);
  // Every queued-but-unfilled entry and every discard slot is a response
  // still owed by fetch, so both count against capacity.
  assign req_ready_o = !flush_i && ((SW'(count_q) + SW'(discard_q)) < SW'(DEPTH));
  assign alloc_s     = req_valid_i && req_ready_o;

  assign head_ent_s     = mem_q[head_q];
  assign head_ready_o   = (count_q != '0) &&
                          (head_ent_s.filled || (fill_now_s && (fill_idx_s == head_q)));
  assign head_inst_o    = head_ent_s.filled ? head_ent_s.inst : inst_rdata_i;
  assign head_pc_o      = head_ent_s.pc;
  assign head_exc_o     = head_ent_s.exc;
  assign head_exccode_o = head_ent_s.exccode;
  assign count_o        = count_q;

  // Next-state for storage, pointers, occupancy and discard count.
  always_comb begin
    mem_d     = mem_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    discard_d = discard_q;
    if (flush_i) begin
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      discard_d = discard_q + unfilled_s - CW'(drop_s);
    end else begin
      if (fill_now_s) begin
        mem_d[fill_idx_s].inst   = inst_rdata_i;
        mem_d[fill_idx_s].filled = 1'b1;
      end else if (inst_data_ok_i && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1'b1);
      end else begin
        discard_d = discard_q;
      end
      if (alloc_s) begin
        mem_d[tail_q].pc      = req_pc_i;
        mem_d[tail_q].exc     = req_exc_i;
        mem_d[tail_q].exccode = req_exccode_i;
        mem_d[tail_q].inst    = 32'd0;
        mem_d[tail_q].filled  = req_exc_i;
        tail_d                = tail_q + PW'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      if (pop_i) begin
        head_d = head_q + PW'(1'b1);
      end else begin
        head_d = head_q;
      end
      count_d = count_q + CW'(alloc_s) - CW'(pop_i);
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q     <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      mem_q     <= mem_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: rtl/decode_queue_stage.sv
// decode_queue_stage: decode front end between fetch and execute.
// Ports: fetch request/response (req_*, inst_*), flush_i, register file
// read (rf_*), NFWD forwarding sources (fwd_*, index 0 youngest), the
// registered issue interface (valid_o/ready_i, pc_o, inst_o, rdata*_o,
// exc_o, exccode_o), queue occupancy and a forwarding-stall counter.
module decode_queue_stage
  import decode_queue_stage_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NFWD  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [31:0]            req_pc_i,
  input  logic                   req_exc_i,
  input  logic [4:0]             req_exccode_i,
  input  logic                   inst_data_ok_i,
  input  logic [31:0]            inst_rdata_i,
  input  logic                   flush_i,
  output logic [4:0]             rf_raddr1_o,
  output logic [4:0]             rf_raddr2_o,
  input  logic [31:0]            rf_rdata1_i,
  input  logic [31:0]            rf_rdata2_i,
  input  logic [5*NFWD-1:0]      fwd_addr_i,
  input  logic [32*NFWD-1:0]     fwd_data_i,
  input  logic [NFWD-1:0]        fwd_ok_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [31:0]            pc_o,
  output logic [31:0]            inst_o,
  output logic [31:0]            rdata1_o,
  output logic [31:0]            rdata2_o,
  output logic                   exc_o,
  output logic [4:0]             exccode_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [31:0]            perf_fwd_stall_o
);

  logic        head_ready_s, head_exc_s, stall_s, issue_s;
  logic [31:0] head_pc_s, head_inst_s;
  logic [4:0]  head_exccode_s;
  logic        hit1_s, ok1_s, hit2_s, ok2_s;
  logic [31:0] op1_s, op2_s;

  logic        valid_q, valid_d, exc_q, exc_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, rdata1_q, rdata1_d, rdata2_q, rdata2_d;
  logic [31:0] perf_q, perf_d;
  logic [4:0]  exccode_q, exccode_d;

  inst_queue #(.DEPTH(DEPTH)) u_queue (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_pc_i       (req_pc_i),
    .req_exc_i      (req_exc_i),
    .req_exccode_i  (req_exccode_i),
    .inst_data_ok_i (inst_data_ok_i),
    .inst_rdata_i   (inst_rdata_i),
    .flush_i        (flush_i),
    .pop_i          (issue_s),
    .head_ready_o   (head_ready_s),
    .head_pc_o      (head_pc_s),
    .head_inst_o    (head_inst_s),
    .head_exc_o     (head_exc_s),
    .head_exccode_o (head_exccode_s),
    .count_o        (count_o)
  );

  assign rf_raddr1_o = inst_rs(head_inst_s);
  assign rf_raddr2_o = inst_rt(head_inst_s);

  // Operand forwarding: scan from oldest to youngest so the lowest
  // matching index is the last to write and therefore wins.
  always_comb begin
    hit1_s = 1'b0;
    ok1_s  = 1'b0;
    op1_s  = rf_rdata1_i;
    hit2_s = 1'b0;
    ok2_s  = 1'b0;
    op2_s  = rf_rdata2_i;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if ((fwd_addr_i[i*5 +: 5] != 5'd0) && (fwd_addr_i[i*5 +: 5] == rf_raddr1_o)) begin
        hit1_s = 1'b1;
        ok1_s  = fwd_ok_i[i];
        op1_s  = fwd_data_i[i*32 +: 32];
      end else begin
        hit1_s = hit1_s;
      end
      if ((fwd_addr_i[i*5 +: 5] != 5'd0) && (fwd_addr_i[i*5 +: 5] == rf_raddr2_o)) begin
        hit2_s = 1'b1;
        ok2_s  = fwd_ok_i[i];
        op2_s  = fwd_data_i[i*32 +: 32];
      end else begin
        hit2_s = hit2_s;
      end
    end
  end

  assign stall_s = !head_exc_s && ((hit1_s && !ok1_s) || (hit2_s && !ok2_s));
  assign issue_s = !flush_i && head_ready_s && !stall_s && (!valid_q || ready_i);

  // Output register and stall counter next-state.
  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rdata1_d  = rdata1_q;
    rdata2_d  = rdata2_q;
    exc_d     = exc_q;
    exccode_d = exccode_q;
    perf_d    = perf_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (issue_s) begin
      valid_d   = 1'b1;
      pc_d      = head_pc_s;
      inst_d    = head_inst_s;
      rdata1_d  = op1_s;
      rdata2_d  = op2_s;
      exc_d     = head_exc_s;
      exccode_d = head_exccode_s;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    if (head_ready_s && stall_s && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end else begin
      perf_d = perf_q;
    end
  end

  // Issue-side registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q   <= 1'b0;
      pc_q      <= 32'd0;
      inst_q    <= 32'd0;
      rdata1_q  <= 32'd0;
      rdata2_q  <= 32'd0;
      exc_q     <= 1'b0;
      exccode_q <= 5'd0;
      perf_q    <= 32'd0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      exc_q     <= exc_d;
      exccode_q <= exccode_d;
      perf_q    <= perf_d;
    end
  end

  assign valid_o          = valid_q;
  assign pc_o             = pc_q;
  assign inst_o           = inst_q;
  assign rdata1_o         = rdata1_q;
  assign rdata2_o         = rdata2_q;
  assign exc_o            = exc_q;
  assign exccode_o        = exccode_q;
  assign perf_fwd_stall_o = perf_q;

endmodule
